// File: rtl/instruction_encoder.sv
// instruction_encoder: packs decoded RV32I fields into instruction words and queues them,
// each tagged with an auto-incrementing word address, for the instruction-memory write path.
module instruction_encoder #(
  parameter int DEPTH = 4,
  parameter int ADDR_W = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               fmt,
  input  logic [6:0]               opcode,
  input  logic [2:0]               funct3,
  input  logic [6:0]               funct7,
  input  logic [4:0]               rs1,
  input  logic [4:0]               rs2,
  input  logic [4:0]               rd,
  input  logic [31:0]              imm,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_word,
  output logic [ADDR_W-1:0]        out_addr,
  input  logic                     addr_load,
  input  logic [ADDR_W-1:0]        addr_val,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err,
  input  logic                     err_clr
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t r_state, w_next;
  logic [31:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_count;
  logic [ADDR_W-1:0] r_addr;
  logic r_err;
  logic [31:0] w_word;
  logic w_bad, w_acc, w_push, w_pop;
  assign in_ready = r_count != (AW+1)'(DEPTH);
  assign out_valid = r_state == ACTIVE;
  assign out_word = out_valid ? r_mem[r_rp] : '0;
  assign out_addr = r_addr;
  assign count = r_count;
  assign err = r_err;
  // Illegal formats and odd branch/jump offsets complete the handshake but are dropped
  assign w_bad = fmt == 3'd7 || ((fmt == 3'd4 || fmt == 3'd6) && imm[0]);
  assign w_acc = in_valid && in_ready;
  assign w_push = w_acc && !w_bad;
  assign w_pop = out_valid && out_ready;
  always_comb begin
    w_word = '0;
    case (fmt)
      3'd0: w_word = {funct7, rs2, rs1, funct3, rd, opcode};
      3'd1: w_word = {imm[11:0], rs1, funct3, rd, opcode};
      3'd2: w_word = {funct7, imm[4:0], rs1, funct3, rd, opcode};
      3'd3: w_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      3'd4: w_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      3'd5: w_word = {imm[31:12], rd, opcode};
      3'd6: w_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: w_word = '0;
    endcase
  end
  always_comb begin
    w_next = (r_state == IDLE) ? (w_push ? ACTIVE : IDLE)
           : ((w_pop && !w_push && r_count == (AW+1)'(1)) ? IDLE : ACTIVE);
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= w_word;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_wp <= '0;
      r_rp <= '0;
      r_count <= '0;
      r_addr <= BASE_ADDR;
      r_err <= 1'b0;
    end else begin
      r_state <= w_next;
      r_wp <= r_wp + AW'(w_push);
      r_rp <= r_rp + AW'(w_pop);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      r_addr <= addr_load ? addr_val : r_addr + ADDR_W'(w_pop);
      r_err <= (w_acc && w_bad) || (r_err && !err_clr);
    end
  end
endmodule
